// File: rtl/detect_frame_ctrl_pkg.sv
// Shared definitions for the detector frame sequencer: FSM encodings and lag limit.
package detect_frame_ctrl_pkg;

    // Largest supported detector flag lag in cycles.
    localparam int unsigned FLAG_LAT_MAX = 3;

    // Sequencer FSM encodings.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/detect_frame_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module detect_frame_ctrl_sat_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Clear wins over increment; increment stops at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/detect_frame_ctrl.sv
// Frame sequencer: resets a serial detector, shifts a captured frame into it MSB-first,
// counts flag pulses inside a lag-compensated window and reports with a done pulse.
module detect_frame_ctrl
    import detect_frame_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned FLAG_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] frame_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             det_din,
    output logic             det_rst,
    input  logic             det_flag
);

    localparam int unsigned BIT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] DRAIN_LAST = BIT_W'((FLAG_LAT > 0) ? (FLAG_LAT - 1) : 0);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             det_din_q, det_din_d;
    logic             det_rst_q, det_rst_d;
    logic             accept;
    logic             in_shift;
    logic             window;

    assign accept   = (state_q == S_IDLE) && start;
    assign in_shift = (state_q == S_SHIFT);

    // Next-state logic; det_din is computed one cycle ahead so the output is a flop.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        det_din_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    shreg_d = frame_data;
                end
            end
            S_CLEAR: begin
                state_d   = S_SHIFT;
                bit_cnt_d = '0;
                det_din_d = shreg_q[WIDTH-1];
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            end
            S_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = (FLAG_LAT > 0) ? S_DRAIN : S_DONE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    det_din_d = shreg_q[WIDTH-1];
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                end
            end
            S_DRAIN: begin
                // Bit counter is reused to time the drain.
                if (bit_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        det_rst_d = (state_d != S_CLEAR);
    end

    // State and registered detector-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            det_din_q <= 1'b0;
            det_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            det_din_q <= det_din_d;
            det_rst_q <= det_rst_d;
        end
    end

    // Count window: SHIFT occupancy delayed by the detector's flag lag.
    if (FLAG_LAT > 0) begin : g_lag
        logic [FLAG_LAT:0] win_line;
        assign win_line[0] = in_shift;
        // Delay line of SHIFT valids.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                win_line[FLAG_LAT:1] <= '0;
            end else begin
                win_line[FLAG_LAT:1] <= win_line[FLAG_LAT-1:0];
            end
        end
        assign window = win_line[FLAG_LAT];
    end else begin : g_nolag
        assign window = in_shift;
    end

    detect_frame_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (window && det_flag),
        .cnt (match_cnt)
    );

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign det_din = det_din_q;
    assign det_rst = det_rst_q;

endmodule
